// File: rtl/add_seq_pkg.sv
// Shared types and defaults for the sequential slice adder.
package add_seq_pkg;

  localparam int SLICE_W_DEF    = 6;
  localparam int NUM_SLICES_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/add_slice.sv
// Combinational W-bit adder slice with flattened carry-lookahead.
module add_slice #(
  parameter int W = 6
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o
);

  logic [W-1:0] g, p;
  logic [W:0]   c;
  logic         acc, pp;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Each carry is the OR of every generate term propagated up to it plus
  // the slice carry-in propagated through all lower bits (no ripple chain).
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    pp   = 1'b0;
    c[0] = c_i;
    for (int i = 0; i < W; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & c_i);
    end
  end

  assign s_o = p ^ c[W-1:0];
  assign c_o = c[W];

endmodule

// File: rtl/add24_seq.sv
// Sequential adder: one SLICE_W-bit slice reused over NUM_SLICES cycles,
// LSB slice first, carry held in a register between cycles.
module add24_seq
  import add_seq_pkg::*;
#(
  parameter int SLICE_W    = SLICE_W_DEF,
  parameter int NUM_SLICES = NUM_SLICES_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [SLICE_W*NUM_SLICES-1:0] in_A,
  input  logic [SLICE_W*NUM_SLICES-1:0] in_B,
  input  logic                          c_in,
  output logic                          busy,
  output logic                          done,
  output logic [SLICE_W*NUM_SLICES-1:0] out,
  output logic                          c_out
);

  localparam int W     = SLICE_W * NUM_SLICES;
  localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SLICES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d, out_q, out_d;
  logic               cy_q, cy_d, cout_q, cout_d;
  logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
  logic               sl_co;

  // Operand slice mux feeding the single shared adder.
  assign sl_a = a_q[idx_q*SLICE_W +: SLICE_W];
  assign sl_b = b_q[idx_q*SLICE_W +: SLICE_W];

  add_slice #(.W(SLICE_W)) u_slice (
    .a_i (sl_a),
    .b_i (sl_b),
    .c_i (cy_q),
    .s_o (sl_s),
    .c_o (sl_co)
  );

  // Next-state and datapath updates; DONE accepts a new start like IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    out_d   = out_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = in_A;
          b_d     = in_B;
          cy_d    = c_in;
          sum_d   = '0;
          idx_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d[idx_q*SLICE_W +: SLICE_W] = sl_s;
        cy_d = sl_co;
        if (idx_q == IDX_LAST) begin
          // Result is published on the same edge that enters DONE.
          idx_d   = '0;
          out_d   = sum_d;
          cout_d  = sl_co;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any in-flight addition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      out_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
    end
  end

  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign out   = out_q;
  assign c_out = cout_q;

endmodule

// File: tb/tb_add24_seq.sv
// Directed bench for add24_seq: outputs sampled on the falling edge.
module tb_add24_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] in_A, in_B;
  logic        c_in;
  logic        busy, done;
  logic [23:0] out;
  logic        c_out;

  int n_vec = 0;
  int n_err = 0;

  add24_seq #(.SLICE_W(6), .NUM_SLICES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in_A  (in_A),
    .in_B  (in_B),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .c_out (c_out)
  );

  always #5 clk = ~clk;

  // Drive one start pulse; returns at the falling edge after the accept edge.
  task automatic launch(input logic [23:0] a, input logic [23:0] b, input logic c);
    @(negedge clk);
    start = 1'b1; in_A = a; in_B = b; c_in = c;
    @(negedge clk);
    start = 1'b0; in_A = 24'h5A5A5A; in_B = 24'hA5A5A5; c_in = ~c;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; in_A = '0; in_B = '0; c_in = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++; $display("FAIL reset_ctl: busy/done=%b expected 00", {busy, done});
    end
    n_vec++;
    if ({c_out, out} !== 25'h0) begin
      n_err++; $display("FAIL reset_out: c_out/out=%h expected 0", {c_out, out});
    end
    // Release and start in the same cycle: first edge must accept it.
    rst = 1'b1; start = 1'b1; in_A = 24'h000001; in_B = 24'h000002; c_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL first_start: busy=%b expected 1", busy);
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if ({done, c_out, out} !== {1'b1, 1'b0, 24'h000003}) begin
      n_err++; $display("FAIL first_result: done=%b c_out=%b out=%h expected 1 0 000003", done, c_out, out);
    end
  endtask

  task automatic test_basic;
    launch(24'h00000A, 24'h00000D, 1'b0);
    // After accept edge and RUN edges 1..3: busy, no done, old result held.
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if ({busy, done, out} !== {1'b1, 1'b0, 24'h000003}) begin
        n_err++; $display("FAIL basic_run%0d: busy=%b done=%b out=%h expected 1 0 000003", k, busy, done, out);
      end
      if (k < 3) @(negedge clk);
    end
    @(negedge clk);
    n_vec++;
    if ({busy, done, c_out, out} !== {1'b0, 1'b1, 1'b0, 24'h000017}) begin
      n_err++; $display("FAIL basic_done: busy=%b done=%b c_out=%b out=%h expected 0 1 0 000017", busy, done, c_out, out);
    end
    @(negedge clk);
    n_vec++;
    if ({busy, done, out} !== {1'b0, 1'b0, 24'h000017}) begin
      n_err++; $display("FAIL basic_hold: busy=%b done=%b out=%h expected 0 0 000017", busy, done, out);
    end
  endtask

  task automatic test_carry;
    logic [23:0] va [5] = '{24'hFFFFFF, 24'hAAAAAA, 24'h123456, 24'h800000, 24'h03F03F};
    logic [23:0] vb [5] = '{24'h000001, 24'h555555, 24'h654321, 24'h800000, 24'h000001};
    logic        vc [5] = '{1'b0,       1'b1,       1'b0,       1'b0,       1'b0};
    logic [24:0] ve [5] = '{25'h1000000, 25'h1000000, 25'h0777777, 25'h1000000, 25'h003F040};
    for (int i = 0; i < 5; i++) begin
      launch(va[i], vb[i], vc[i]);
      repeat (4) @(negedge clk);
      n_vec++;
      if ({done, c_out, out} !== {1'b1, ve[i]}) begin
        n_err++; $display("FAIL carry%0d: done=%b c_out=%b out=%h expected 1 %b %h", i, done, c_out, out, ve[i][24], ve[i][23:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    launch(24'hFFFFFF, 24'hFFFFFF, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1; in_A = 24'h000000; in_B = 24'h000000; c_in = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({done, c_out, out} !== {1'b1, 1'b1, 24'hFFFFFF}) begin
      n_err++; $display("FAIL b2b_first: done=%b c_out=%b out=%h expected 1 1 ffffff", done, c_out, out);
    end
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if ({busy, done, out} !== {1'b1, 1'b0, 24'hFFFFFF}) begin
      n_err++; $display("FAIL b2b_gap: busy=%b done=%b out=%h expected 1 0 ffffff", busy, done, out);
    end
    repeat (3) @(negedge clk);
    @(negedge clk);
    n_vec++;
    if ({done, c_out, out} !== {1'b1, 1'b0, 24'h000001}) begin
      n_err++; $display("FAIL b2b_second: done=%b c_out=%b out=%h expected 1 0 000001", done, c_out, out);
    end
  endtask

  task automatic test_ignore_start;
    int ndone;
    launch(24'h00000A, 24'h00000D, 1'b0);
    @(negedge clk);
    start = 1'b1; in_A = 24'h111111; in_B = 24'h111111;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL ign_busy: busy=%b expected 1", busy);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL ign_busy2: busy=%b expected 1", busy);
    end
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        n_vec++;
        if ({c_out, out} !== 25'h0000017) begin
          n_err++; $display("FAIL ign_out: c_out=%b out=%h expected 0 000017", c_out, out);
        end
      end
    end
    n_vec++;
    if (ndone != 1) begin
      n_err++; $display("FAIL ign_count: done pulses=%0d expected 1", ndone);
    end
  endtask

  task automatic test_reset_mid_run;
    int nbad;
    launch(24'h000003, 24'h000004, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, c_out, out} !== 27'h0) begin
      n_err++; $display("FAIL mid_rst: busy=%b done=%b c_out=%b out=%h expected all 0", busy, done, c_out, out);
    end
    @(negedge clk);
    rst = 1'b1;
    nbad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if ({busy, done, c_out, out} !== 27'h0) nbad++;
    end
    n_vec++;
    if (nbad != 0) begin
      n_err++; $display("FAIL mid_rst_quiet: %0d cycles with activity expected 0", nbad);
    end
    launch(24'h000003, 24'h000004, 1'b0);
    repeat (4) @(negedge clk);
    n_vec++;
    if ({done, c_out, out} !== {1'b1, 1'b0, 24'h000007}) begin
      n_err++; $display("FAIL mid_rst_after: done=%b c_out=%b out=%h expected 1 0 000007", done, c_out, out);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_back_to_back;
    test_ignore_start;
    test_reset_mid_run;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/add24_seq.md
ADD24_SEQ -- requirements
Module: add24_seq

Interface
REQ-001 Parameter SLICE_W, default 6, width of one adder slice in bits.
REQ-002 Parameter NUM_SLICES, default 4, number of slices per operand; operand width W = SLICE_W*NUM_SLICES (24).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to begin an addition; sampled on the rising edge.
REQ-006 in_A  input  W  operand A; sampled only when start is accepted.
REQ-007 in_B  input  W  operand B; sampled only when start is accepted.
REQ-008 c_in  input  1  carry-in; sampled only when start is accepted.
REQ-009 busy  output  1  high while an addition is in progress.
REQ-010 done  output  1  one-cycle pulse marking a completed addition.
REQ-011 out  output  W  sum of the last completed addition.
REQ-012 c_out  output  1  carry-out of the last completed addition.

Function
REQ-013 The block SHALL compute {c_out,out} = in_A + in_B + c_in by time-sharing one SLICE_W-bit adder slice across NUM_SLICES cycles, LSB slice first.
REQ-014 FSM states: IDLE, RUN, DONE.
REQ-015 IDLE: busy=0, done=0; start=1 -> latch in_A, in_B, c_in into working registers, clear slice index to 0, go to RUN.
REQ-016 RUN: busy=1; each cycle add slice[idx] of A and B plus the carry register, write the SLICE_W-bit result into slice[idx] of the working sum, load the slice carry-out into the carry register, increment idx.
REQ-017 RUN with idx = NUM_SLICES-1: after the slice update, go to DONE; idx wraps to 0.
REQ-018 DONE: busy=0, done=1 for exactly one cycle; out and c_out are loaded from the working sum and carry register on the DONE-entry edge and are valid while done=1.
REQ-019 Latency: start accepted at edge 0; RUN occupies edges 1..NUM_SLICES; done=1 in the cycle after edge NUM_SLICES (5 cycles from start to done at defaults).
REQ-020 out/c_out SHALL hold their value until the next completion; they do not change during RUN.
REQ-021 start while in RUN SHALL be ignored; operands are not re-sampled and the in-flight operation is unaffected.
REQ-022 start while in DONE SHALL be accepted exactly as in IDLE (back-to-back, no idle cycle); without start, DONE goes to IDLE.
REQ-023 Slice arithmetic is modulo 2^SLICE_W with explicit carry; carry propagates across all slices (e.g. 0xFFFFFF+1 ripples through 4 slices).

Reset
REQ-024 rst=0 SHALL immediately force state=IDLE, idx=0, busy=0, done=0, out=0, c_out=0, working registers=0, regardless of clk.
REQ-025 Reset asserted mid-RUN SHALL abort the operation; no done pulse and no update of out/c_out follows.
REQ-026 First start SHALL be accepted on the first rising edge after rst returns high.

Structure
REQ-027 Shared package add_seq_pkg SHALL hold the FSM state enumeration and the default constants SLICE_W=6, NUM_SLICES=4.
REQ-028 The adder slice SHALL be a separate combinational sub-module add_slice (SLICE_W-bit A, B, carry-in -> sum, carry-out, carry-lookahead internally); add24_seq instantiates exactly one.
REQ-029 Slice operand selection SHALL be a mux indexed by idx; no per-slice adders.

Verification
REQ-030 in_A=0x00000A, in_B=0x00000D, c_in=0, start pulse -> done 5 cycles later, out=0x000017, c_out=0.
REQ-031 in_A=0xFFFFFF, in_B=0x000001, c_in=0 -> out=0x000000, c_out=1; in_A=0xAAAAAA, in_B=0x555555, c_in=1 -> out=0x000000, c_out=1.
REQ-032 in_A=0xFFFFFF, in_B=0xFFFFFF, c_in=1 -> out=0xFFFFFF, c_out=1; then start held high in DONE with 0x000000+0x000000, c_in=1 -> next done yields out=0x000001, c_out=0, no idle cycle between operations.
REQ-033 start with 0x00000A+0x00000D, then start with 0x111111+0x111111 on cycle 2 of RUN -> single done, out=0x000017; second request ignored, busy stays high throughout.
REQ-034 rst=0 for 1 cycle during RUN cycle 3 -> busy, done, out, c_out at 0 immediately, no done pulse afterwards; subsequent start completes correctly.
